// File: rtl/gates_chk_pkg.sv
// Shared state encoding and output bit map for the gate-block checker.
package gates_chk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      NEXT,
      DONE
   } state_e;

   localparam int unsigned AND_B  = 0;
   localparam int unsigned OR_B   = 1;
   localparam int unsigned NAND_B = 2;
   localparam int unsigned NOR_B  = 3;
   localparam int unsigned XOR_B  = 4;
   localparam int unsigned XNOR_B = 5;

endpackage

// File: rtl/gates_ref_model.sv
// Combinational golden model of the six-output gate block.
module gates_ref_model
   import gates_chk_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [5:0] exp
);

   always_comb begin
      exp         = '0;
      exp[AND_B]  = a & b;
      exp[OR_B]   = a | b;
      exp[NAND_B] = ~(a & b);
      exp[NOR_B]  = ~(a | b);
      exp[XOR_B]  = a ^ b;
      exp[XNOR_B] = ~(a ^ b);
   end

endmodule

// File: rtl/gates_checker.sv
// Sweeps all a/b vectors into a gate block and checks its outputs against a reference model.
// Define GATES_CHECKER_FAIL_LOG_EN to capture the first failing vector and its mismatch mask.
module gates_checker
   import gates_chk_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned PASSES        = 1,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       y_in,
   output logic             a_out,
   output logic             b_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [1:0]       fail_vec,
   output logic [5:0]       fail_mask
);

   localparam int unsigned CntW  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [CntW-1:0]  SettleInit = CntW'(SETTLE_CYCLES);
   localparam logic [PassW-1:0] PassLast   = PassW'(PASSES - 1);
   localparam logic [ERR_W-1:0] ErrMax     = '1;

   state_e           state_q, state_d;
   logic [1:0]       vec_q, vec_d;
   logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             a_q, a_d, b_q, b_d;
   logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [5:0]       exp_v, mask;
   logic             start_ok;

   gates_ref_model u_ref (
      .a   (a_q),
      .b   (b_q),
      .exp (exp_v)
   );

   assign mask     = y_in ^ exp_v;
   assign start_ok = start && (state_q == IDLE || state_q == DONE);

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      pass_cnt_d = pass_cnt_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      err_d      = err_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               err_d      = '0;
               vec_d      = '0;
               pass_cnt_d = '0;
               state_d    = DRIVE;
            end
         end
         DRIVE: begin
            a_d     = vec_q[1];
            b_d     = vec_q[0];
            cnt_d   = SettleInit;
            state_d = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
         end
         SETTLE: begin
            if (cnt_q <= CntW'(1)) state_d = CHECK;
            else cnt_d = cnt_q - CntW'(1);
         end
         CHECK: begin
            // One count per failing vector, regardless of how many bits differ.
            if (mask != '0 && err_q != ErrMax) err_d = err_q + ERR_W'(1);
            state_d = NEXT;
         end
         NEXT: begin
            if (vec_q != 2'd3) begin
               vec_d   = vec_q + 2'd1;
               state_d = DRIVE;
            end else if (pass_cnt_q == PassLast) begin
               state_d = DONE;
            end else begin
               pass_cnt_d = pass_cnt_q + PassW'(1);
               vec_d      = '0;
               state_d    = DRIVE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d inside {DRIVE, SETTLE, CHECK, NEXT});
      done_d = (state_d == DONE);
      if (state_d != DONE) pass_d = 1'b0;
      else if (state_q != DONE) pass_d = (err_q == '0);
      else pass_d = pass_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         pass_cnt_q <= '0;
         cnt_q      <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         pass_cnt_q <= pass_cnt_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
      end
   end

   assign a_out   = a_q;
   assign b_out   = b_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign pass    = pass_q;
   assign err_cnt = err_q;

`ifdef GATES_CHECKER_FAIL_LOG_EN
   logic       fv_q, fv_d;
   logic [1:0] fvec_q, fvec_d;
   logic [5:0] fmask_q, fmask_d;

   always_comb begin
      fv_d    = fv_q;
      fvec_d  = fvec_q;
      fmask_d = fmask_q;
      if (start_ok) begin
         fv_d    = 1'b0;
         fvec_d  = '0;
         fmask_d = '0;
      end else if (state_q == CHECK && mask != '0 && !fv_q) begin
         fv_d    = 1'b1;
         fvec_d  = vec_q;
         fmask_d = mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fv_q    <= 1'b0;
         fvec_q  <= '0;
         fmask_q <= '0;
      end else begin
         fv_q    <= fv_d;
         fvec_q  <= fvec_d;
         fmask_q <= fmask_d;
      end
   end

   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;
   assign fail_mask  = fmask_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
   assign fail_valid      = 1'b0;
   assign fail_vec        = 2'b00;
   assign fail_mask       = 6'b000000;
`endif

endmodule

// File: tb/tb_gates_checker.sv
// Scoreboard bench for gates_checker: default, zero-settle and saturating instances.
module tb_gates_checker;

`ifdef GATES_CHECKER_FAIL_LOG_EN
   localparam bit LogEn = 1'b1;
`else
   localparam bit LogEn = 1'b0;
`endif

   typedef struct {
      int err;
      int pass;
      int fv;
      int fvec;
      int fmask;
      int lat;
      int st;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [5:0] gate(input logic a, input logic b);
      gate = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
   endfunction

   // Main instance, defaults, optional XOR stuck-at-0 fault
   logic       start_m = 1'b0, fault = 1'b0;
   logic [5:0] y_m;
   logic       m_a, m_b, m_busy, m_done, m_pass, m_fv;
   logic [7:0] m_err;
   logic [1:0] m_fvec;
   logic [5:0] m_fmask;

   always_comb y_m = fault ? (gate(m_a, m_b) & 6'b101111) : gate(m_a, m_b);

   gates_checker u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_m), .y_in(y_m),
      .a_out(m_a), .b_out(m_b), .busy(m_busy), .done(m_done), .pass(m_pass),
      .err_cnt(m_err), .fail_valid(m_fv), .fail_vec(m_fvec), .fail_mask(m_fmask)
   );

   // Zero-settle, two-pass instance with a correct gate block
   logic       start_f = 1'b0;
   logic [5:0] y_f;
   logic       f_a, f_b, f_busy, f_done, f_pass, f_fv;
   logic [7:0] f_err;
   logic [1:0] f_fvec;
   logic [5:0] f_fmask;

   always_comb y_f = gate(f_a, f_b);

   gates_checker #(.SETTLE_CYCLES(0), .PASSES(2)) u_fast (
      .clk(clk), .rst_n(rst_n), .start(start_f), .y_in(y_f),
      .a_out(f_a), .b_out(f_b), .busy(f_busy), .done(f_done), .pass(f_pass),
      .err_cnt(f_err), .fail_valid(f_fv), .fail_vec(f_fvec), .fail_mask(f_fmask)
   );

   // 100 passes against outputs stuck high: counter must saturate
   logic       start_s = 1'b0;
   logic       s_a, s_b, s_busy, s_done, s_pass, s_fv;
   logic [7:0] s_err;
   logic [1:0] s_fvec;
   logic [5:0] s_fmask;

   gates_checker #(.PASSES(100), .ERR_W(8)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start_s), .y_in(6'b111111),
      .a_out(s_a), .b_out(s_b), .busy(s_busy), .done(s_done), .pass(s_pass),
      .err_cnt(s_err), .fail_valid(s_fv), .fail_vec(s_fvec), .fail_mask(s_fmask)
   );

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // Monitor: pops an expectation on every rising edge of done
   logic done_prev = 1'b0;
   always @(posedge clk) begin
      exp_t it;
      #1;
      if (m_done && !done_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            it = exp_q.pop_front();
            check("latency", cyc - it.st + 1, it.lat);
            check("err_cnt", int'(m_err), it.err);
            check("pass", int'(m_pass), it.pass);
            check("busy_at_done", int'(m_busy), 0);
            check("fail_valid", int'(m_fv), it.fv);
            check("fail_vec", int'(m_fvec), it.fvec);
            check("fail_mask", int'(m_fmask), it.fmask);
         end
      end
      done_prev = m_done;
   end

   task automatic push(input int err, input int pass, input int fv, input int fvec,
                       input int fmask, input int st);
      exp_t it;
      it.err = err; it.pass = pass; it.fv = fv; it.fvec = fvec; it.fmask = fmask;
      it.lat = 21; it.st = st;
      exp_q.push_back(it);
   endtask

   task automatic wait_done_m(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (m_done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check("timeout_main", 0, 1);
   endtask

   initial begin
      int at, st;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_a", int'(m_a), 0);
      check("rst_b", int'(m_b), 0);
      check("rst_busy", int'(m_busy), 0);
      check("rst_done", int'(m_done), 0);
      check("rst_pass", int'(m_pass), 0);
      check("rst_err", int'(m_err), 0);
      check("rst_fv", int'(m_fv), 0);
      check("rst_fvec", int'(m_fvec), 0);
      check("rst_fmask", int'(m_fmask), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Correct gates
      push(0, 1, 0, 0, 0, cyc + 1);
      start_m = 1'b1;
      @(negedge clk) start_m = 1'b0;
      wait_done_m(40, at);

      // XOR stuck at 0: vectors 01 and 10 fail
      fault = 1'b1;
      @(negedge clk);
      push(2, 0, LogEn ? 1 : 0, LogEn ? 1 : 0, LogEn ? 6'b010000 : 0, cyc + 1);
      start_m = 1'b1;
      @(negedge clk) start_m = 1'b0;
      wait_done_m(40, at);

      // Start held high: first run must not restart, second starts from DONE
      @(negedge clk);
      push(2, 0, LogEn ? 1 : 0, LogEn ? 1 : 0, LogEn ? 6'b010000 : 0, cyc + 1);
      start_m = 1'b1;
      wait_done_m(40, at);
      fault = 1'b0;
      push(0, 1, 0, 0, 0, at + 1);
      @(posedge clk);
      #1;
      check("restart_err_cleared", int'(m_err), 0);
      check("restart_busy", int'(m_busy), 1);
      @(negedge clk) start_m = 1'b0;
      wait_done_m(40, at);

      // Asynchronous reset during SETTLE of vec=2
      fault = 1'b1;
      @(negedge clk);
      st = cyc + 1;
      start_m = 1'b1;
      @(negedge clk) start_m = 1'b0;
      while (cyc < st + 12) @(posedge clk);
      #3;
      check("pre_rst_err", int'(m_err), 1);
      check("pre_rst_a", int'(m_a), 1);
      rst_n = 1'b0;
      #1;
      check("arst_a", int'(m_a), 0);
      check("arst_busy", int'(m_busy), 0);
      check("arst_err", int'(m_err), 0);
      check("arst_fv", int'(m_fv), 0);
      check("arst_done", int'(m_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      fault = 1'b0;
      @(negedge clk);
      push(0, 1, 0, 0, 0, cyc + 1);
      start_m = 1'b1;
      @(negedge clk) start_m = 1'b0;
      wait_done_m(40, at);

      // Zero-settle, two passes: 3 cycles per vector
      @(negedge clk);
      start_f = 1'b1;
      @(posedge clk);
      st = cyc + 1;
      @(negedge clk) start_f = 1'b0;
      for (int k = 0; k < 8; k++) begin
         logic [1:0] kv;
         kv = 2'(k);
         while (cyc < st + 1 + 3 * k) @(posedge clk);
         #1;
         check("fast_vec", int'({f_a, f_b}), int'(kv));
      end
      while (cyc < st + 23) @(posedge clk);
      #1;
      check("fast_done_early", int'(f_done), 0);
      @(posedge clk);
      #1;
      check("fast_done", int'(f_done), 1);
      check("fast_pass", int'(f_pass), 1);
      check("fast_err", int'(f_err), 0);

      // Saturation: 400 failing vectors, 8-bit counter
      @(negedge clk);
      st = cyc + 1;
      start_s = 1'b1;
      @(negedge clk) start_s = 1'b0;
      at = -1;
      for (int i = 0; i < 2200; i++) begin
         @(posedge clk);
         #1;
         if (s_done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check("timeout_sat", 0, 1);
      else begin
         check("sat_latency", at - st + 1, 2001);
         check("sat_err", int'(s_err), 255);
         check("sat_pass", int'(s_pass), 0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gates_checker.md
Name: gates_checker

Overview:
- Self-checking driver/monitor for a two-input, six-output logic-gate block (AND, OR, NAND, NOR, XOR, XNOR).
- Drives the block's a/b inputs and reads back its six outputs.
- Sweeps all four input vectors, waits a settle interval, then compares against an internal reference model.
- Reports mismatch count and a pass/fail flag. Sits beside the gate block in board bring-up and self-test builds.

Parameters:
- SETTLE_CYCLES, 2: clock cycles between driving a vector and sampling y_in; 0 allowed.
- PASSES, 1: full 4-vector sweeps per run; minimum 1.
- ERR_W, 8: width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- y_in  in  6  gate outputs under test. Bit map: [0]=AND, [1]=OR, [2]=NAND, [3]=NOR, [4]=XOR, [5]=XNOR.
- a_out  out  1  drive to gate input a.
- b_out  out  1  drive to gate input b.
- busy  out  1  high from DRIVE through NEXT.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  valid while done=1; equals (err_cnt==0).
- err_cnt  out  ERR_W  count of failing vectors; saturating.
- fail_valid  out  1  first-failure capture valid.
- fail_vec  out  2  {a,b} of the first failing vector.
- fail_mask  out  6  y_in XOR expected at the first failure.

Behaviour:
- One clock. Reset is asynchronous, active-low, on rst_n; clk is the only clock.
- Reset: state=IDLE. a_out, b_out, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_mask all 0. Internal vec=0, pass_cnt=0. Reset mid-run aborts immediately; no partial result survives.
- Vector order: vec counts 0..3; a_out=vec[1], b_out=vec[0].
- IDLE: on start=1, clear err_cnt, all fail_* outputs, vec and pass_cnt, then go to DRIVE.
- DONE: start=1 behaves as in IDLE (clears done/pass, restarts). start=0 holds.
- DRIVE (1 cycle): register a_out/b_out from vec; load settle counter with SETTLE_CYCLES. Go to SETTLE, or straight to CHECK if SETTLE_CYCLES=0.
- SETTLE (SETTLE_CYCLES cycles): count down; at terminal count go to CHECK.
- CHECK (1 cycle): mask = y_in ^ expected(vec).
  - If mask≠0: err_cnt++, saturating at 2^ERR_W−1. One count per failing vector, not per bit.
- NEXT (1 cycle):
  - If vec≠3: vec++ and go to DRIVE.
  - Else if pass_cnt==PASSES−1: go to DONE.
  - Else: pass_cnt++, vec wraps to 0, go to DRIVE.
- Entering DONE: busy=0, done=1, pass=(err_cnt==0). a_out/b_out hold the last vector.
- start while busy is ignored; it does not queue.
- Latency: from the cycle start is sampled to done=1 is 1 + 4·PASSES·(3+SETTLE_CYCLES) cycles. Default is 21 cycles.
- a_out and b_out are registered, so there is no glitching toward the device under test.

Optional Feature:
- Macro: GATES_CHECKER_FAIL_LOG_EN.
- Defined:
  - On the first CHECK with mask≠0 in a run, latch fail_vec=vec, fail_mask=mask, fail_valid=1.
  - Later failures do not overwrite the capture.
  - Capture is cleared on start and on reset.
- Undefined: fail_valid, fail_vec and fail_mask are tied to 0. Port list is unchanged.

Decomposition:
- Package gates_chk_pkg holds:
  - state encoding constants: IDLE, DRIVE, SETTLE, CHECK, NEXT, DONE;
  - output bit-index constants, AND_B..XNOR_B = 0..5.
- Sub-module gates_ref_model: purely combinational, in a(1), b(1) → exp(6), using the same bit map. Instantiated once and fed from a_out/b_out.

Test Plan:
- Correct gate model, defaults: start pulse → done=1 exactly 21 cycles later; pass=1, err_cnt=0, fail_valid=0.
- Faulty XOR (y_in[4] stuck 0), with GATES_CHECKER_FAIL_LOG_EN defined → err_cnt=2, pass=0, fail_vec=2'b01, fail_mask=6'b010000.
- y_in stuck 6'b111111, PASSES=100, ERR_W=8 → all 400 vectors fail; err_cnt saturates at 255; pass=0.
- rst_n asserted during SETTLE of vec=2 → all outputs 0 asynchronously, state IDLE. A new start then runs cleanly: pass=1 after 21 cycles.
- start held high through a run → no restart while busy. Run completes at cycle 21, then restarts from DONE on the next sampled start with err_cnt cleared.
- SETTLE_CYCLES=0, PASSES=2 → done after 1+8·3=25 cycles. a_out/b_out sequence is 00,01,10,11,00,01,10,11.
